fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one first-word-fall-through `fifo` write port among N requesters. Each requester presents a valid/ready stream with a `last` marker; the arbiter locks the FIFO to one requester for a whole burst, so bursts are never interleaved. It sits directly in front of the `fifo` instance and drives its `din`/`wr_en`, honouring `full`.

---
 rtl/fifo_wr_arbiter_if.sv | 16 +
 rtl/fifo_wr_arbiter.sv | 85 ++++++++
 tb/tb_fifo_wr_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester streams plus the shared FIFO write port seen by fifo_wr_arbiter.
interface fifo_wr_arbiter_if #(parameter int WIDTH = 8, parameter int N = 4);
  logic [N-1:0]       req_valid;
  logic [N*WIDTH-1:0] req_data;
  logic [N-1:0]       req_last;
  logic [N-1:0]       req_ready;
  logic [WIDTH-1:0]   fifo_din;
  logic               fifo_wr_en;
  logic               fifo_full;
  logic [N-1:0]       grant;
  logic               busy;
  modport master (output req_valid, req_data, req_last, fifo_full,
                  input  req_ready, fifo_din, fifo_wr_en, grant, busy);
  modport slave  (input  req_valid, req_data, req_last, fifo_full,
                  output req_ready, fifo_din, fifo_wr_en, grant, busy);
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-locked arbiter sharing one FIFO write port among N requesters.
// Define FIFO_ARB_PRIO0_EN to give requester 0 strict priority at each arbitration.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int N         = 4,
  parameter int MAX_BURST = 16
) (
  input logic               clk,
  input logic               srst,
  fifo_wr_arbiter_if.slave  bus
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IW-1:0]  own_q, own_d, ptr_q, ptr_d, sel, j;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, found, locked, xfer;
  // Reset gates the write path so an abandoned burst never writes in the reset cycle
  assign locked         = state_q == LOCKED && !srst;
  assign xfer           = locked && bus.req_valid[own_q] && !bus.fifo_full;
  assign bus.req_ready  = (locked && !bus.fifo_full) ? grant_q : '0;
  assign bus.fifo_wr_en = xfer;
  assign bus.fifo_din   = locked ? bus.req_data[own_q*WIDTH +: WIDTH] : '0;
  assign bus.grant      = grant_q;
  assign bus.busy       = busy_q;
  always_comb begin
    sel   = ptr_q;
    found = 1'b0;
    j     = '0;
`ifdef FIFO_ARB_PRIO0_EN
    if (bus.req_valid[0]) begin
      sel   = '0;
      found = 1'b1;
    end
`endif
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(ptr_q) + k) % N);
      if (!found && bus.req_valid[j]) begin
        sel   = j;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (found) begin
        state_d = LOCKED;
        own_d   = sel;
        grant_d = N'(1) << sel;
        cnt_d   = '0;
      end
    end else if (xfer) begin
      cnt_d = cnt_q + CW'(1);
      if (bus.req_last[own_q] || cnt_d == CW'(MAX_BURST)) begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d   = own_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= IDLE;
      grant_q <= '0;
      own_q   <= '0;
      ptr_q   <= IW'(N - 1);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= |grant_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized requester sources, cycle-level reference model and scoreboard monitor.
module tb_fifo_wr_arbiter;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int MB = 16;
  typedef struct packed {
    logic [N-1:0] grant;
    logic [N-1:0] ready;
    logic         wr;
    logic         busy;
    logic [W-1:0] din;
  } exp_t;
  logic clk = 1'b0;
  logic srst;
  fifo_wr_arbiter_if #(.WIDTH(W), .N(N)) bus();
  fifo_wr_arbiter #(.WIDTH(W), .N(N), .MAX_BURST(MB)) dut (.clk(clk), .srst(srst), .bus(bus.slave));
  always #5 clk = ~clk;
  logic [W:0]   srcq[N][$];
  exp_t         sbq[$];
  logic [N-1:0] fire;
  bit           gaps, rand_full, full_force, rst_force, done, timeout;
  int           n_cmp = 0, n_err = 0;
  int           m_own = -1, m_ptr = N - 1, m_cnt = 0;
  task automatic add_burst(input int r, input int len);
    for (int b = 0; b < len; b++) srcq[r].push_back({b == len - 1, W'($urandom)});
  endtask
  function automatic bit pending();
    for (int i = 0; i < N; i++) if (srcq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction
  task automatic drive();
    logic [W:0] h;
    logic       v;
    for (int i = 0; i < N; i++) begin
      v = srcq[i].size() > 0 && (!gaps || $urandom_range(0, 3) != 0);
      h = v ? srcq[i][0] : {1'($urandom), W'($urandom)};
      bus.req_valid[i] = v;
      bus.req_data[i*W +: W] = h[W-1:0];
      bus.req_last[i] = h[W];
    end
    bus.fifo_full = full_force || (rand_full && $urandom_range(0, 2) == 0);
    srst = rst_force;
  endtask
  task automatic cycle();
    @(negedge clk);
    fire = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    drive();
  endtask
  task automatic drain(input int bound);
    int k = 0;
    while (pending() && k < bound) begin
      cycle();
      k++;
    end
    if (pending()) timeout = 1'b1;
    repeat (3) cycle();
  endtask
  initial begin
    rst_force = 1'b1; gaps = 1'b0; rand_full = 1'b0; full_force = 1'b0;
    done = 1'b0; timeout = 1'b0;
    drive();
    repeat (3) cycle();
    rst_force = 1'b0;
    add_burst(2, 3);
    drain(50);
    for (int r = 0; r < 6; r++) for (int i = 0; i < N; i++) add_burst(i, 1);
    drain(200);
    add_burst(1, 4);
    cycle(); cycle();
    full_force = 1'b1;
    cycle(); cycle();
    full_force = 1'b0;
    drain(50);
    add_burst(1, 20);
    cycle(); cycle();
    add_burst(3, 2);
    drain(100);
    add_burst(3, 5);
    repeat (3) cycle();
    rst_force = 1'b1;
    add_burst(0, 2);
    cycle();
    rst_force = 1'b0;
    drain(50);
    add_burst(0, 1);
    drain(20);
    add_burst(0, 1);
    add_burst(1, 1);
    drain(20);
    gaps = 1'b1;
    rand_full = 1'b1;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 7) == 0) add_burst($urandom_range(0, N - 1), $urandom_range(1, 20));
      rst_force = $urandom_range(0, 249) == 0;
      cycle();
    end
    rst_force = 1'b0;
    drain(4000);
    done = 1'b1;
  end
  // Reference model: integer owner/pointer/beat count derived from the arbitration rules
  initial begin
    exp_t e;
    int   pick;
    forever begin
      @(posedge clk);
      #2;
      e.grant = (m_own >= 0) ? N'(1) << m_own : '0;
      e.busy  = m_own >= 0;
      e.ready = (m_own >= 0 && !bus.fifo_full && !srst) ? e.grant : '0;
      e.wr    = m_own >= 0 && bus.req_valid[m_own] && !bus.fifo_full && !srst;
      e.din   = e.wr ? bus.req_data[m_own*W +: W] : '0;
      sbq.push_back(e);
      if (srst) begin
        m_own = -1; m_ptr = N - 1; m_cnt = 0;
      end else if (m_own < 0) begin
        pick = -1;
`ifdef FIFO_ARB_PRIO0_EN
        if (bus.req_valid[0]) pick = 0;
`endif
        for (int k = 1; k <= N; k++)
          if (pick < 0 && bus.req_valid[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
        if (pick >= 0) begin
          m_own = pick; m_cnt = 0;
        end
      end else if (e.wr) begin
        m_cnt++;
        if (bus.req_last[m_own] || m_cnt == MB) begin
          m_ptr = m_own; m_own = -1;
        end
      end
    end
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) break;
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL scoreboard_empty @%0t: got 0 entries expected 1", $time);
      end else begin
        e = sbq.pop_front();
        check("grant", 32'(bus.grant), 32'(e.grant));
        check("busy", 32'(bus.busy), 32'(e.busy));
        check("req_ready", 32'(bus.req_ready), 32'(e.ready));
        check("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(e.wr));
        if (e.wr) check("fifo_din", 32'(bus.fifo_din), 32'(e.din));
      end
    end
    check("drain_timeout", 32'(timeout), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
